fll_cfg_ctrl: RTL
=================

// Module: fll_cfg_ctrl
// PURPOSE
//  Sequencer for the FLL macro configuration port (4-phase req/ack, 2-bit addr, 32-bit data).
//  After reset it releases FLL reset, programs boot config words and waits for lock (with timeout).
//  Afterwards it serves single read/write accesses from a SoC-side register port.
//  Sits between the SoC peripheral bus and the FLL wrapper; sole driver of the FLL cfg pins.
// PARAMETERS
//  BOOT_EN       1              1: run boot sequence after reset; 0: go straight to READY
//  BOOT_CFG1     32'h0000_0000  word written to FLL addr 2'd1 during boot
//  BOOT_CFG2     32'h0000_0000  word written to FLL addr 2'd2 during boot
//  RST_CYCLES    16             cycles fll_rst_no held low after rst_ni deasserts (>=1)
//  ACK_TIMEOUT   256            max cycles waiting for each ack edge (>=2)
//  LOCK_TIMEOUT  65535          max cycles waiting for lock after boot (<2^16)
// PORTS
//  clk_i         in   1   system clock
//  rst_ni        in   1   synchronous reset, active low
//  sw_req_i      in   1   SoC access request
//  sw_we_i       in   1   1=write, 0=read
//  sw_addr_i     in   2   FLL cfg address
//  sw_wdata_i    in   32  write data
//  sw_gnt_o      out  1   1-cycle pulse: request accepted
//  sw_rvalid_o   out  1   1-cycle pulse: access complete (reads and writes)
//  sw_rdata_o    out  32  read data, valid with sw_rvalid_o
//  sw_err_o      out  1   with sw_rvalid_o: ack timeout occurred
//  fll_rst_no    out  1   FLL reset (RSTB)
//  fll_req_o     out  1   FLL CFGREQ
//  fll_ack_i     in   1   FLL CFGACK (asynchronous)
//  fll_addr_o    out  2   FLL CFGAD
//  fll_wdata_o   out  32  FLL CFGD
//  fll_wr_no     out  1   FLL CFGWEB (0=write)
//  fll_rdata_i   in   32  FLL CFGQ
//  fll_lock_i    in   1   FLL LOCK (asynchronous)
//  ready_o       out  1   boot done, SoC port accepting
//  locked_o      out  1   synchronised fll_lock_i
//  boot_err_o    out  1   sticky: boot ack or lock timeout
// BEHAVIOUR
//  - Reset (rst_ni=0 at posedge): all outputs 0, except fll_wr_no=1; FSM->RST_HOLD; sync flops cleared.
//  - fll_ack_i, fll_lock_i pass 2-FF synchronisers (2-cycle latency); locked_o = synced lock.
//  - FSM: RST_HOLD -> (BOOT_EN ? BOOT1 : READY); BOOT1 -> BOOT2 -> WAIT_LOCK -> READY;
//    READY -> ACCESS on sw_req_i; ACCESS -> READY. BOOTx/ACCESS run the XFER sub-sequence.
//  - RST_HOLD: fll_rst_no=0 for RST_CYCLES cycles, then 1 (stays 1 until rst_ni).
//  - XFER: cycle 0 drive addr/wdata/wr_no, fll_req_o=1; hold all stable until synced ack=1;
//    capture fll_rdata_i (synced cycle), drop req; wait synced ack=0; transfer done.
//    addr/wdata/wr_no remain stable until ack low observed. Never two req without ack low between.
//  - Ack timeout: counter reset at each phase; hitting ACK_TIMEOUT drops req, sets error,
//    then waits for ack low (max ACK_TIMEOUT more) before finishing; if still high, finish anyway.
//  - Boot: BOOT1 writes BOOT_CFG1 @1, BOOT2 writes BOOT_CFG2 @2; then WAIT_LOCK until locked_o=1
//    or LOCK_TIMEOUT cycles. Any timeout -> boot_err_o=1 (sticky), sequence still reaches READY.
//  - READY: ready_o=1. sw_req_i=1 -> sw_gnt_o pulse same cycle, inputs latched, ACCESS.
//    sw_req_i while not READY/ACCESS-complete is ignored (no gnt); requester holds req.
//  - ACCESS done: sw_rvalid_o pulse; sw_rdata_o = captured data on read, 0 on write;
//    sw_err_o = ack timeout flag. Returns to READY next cycle (no back-to-back gnt on done cycle).
//  - Lock loss in READY: only reflected on locked_o; no automatic reprogram.
//  - rst_ni low mid-transfer: immediate synchronous abort, req=0, restart from RST_HOLD.
// TESTING
//  1. BOOT_EN=1, CFG1=32'h0000_05F5, CFG2=32'h1: FLL model acks in 3 cycles, lock after 100
//     -> fll_rst_no high after 16 cycles, writes @1 then @2, ready_o=1, boot_err_o=0.
//  2. Read @3 in READY, model returns 32'hDEAD_BEEF -> gnt pulse, one req/ack pair,
//     rvalid with rdata=32'hDEAD_BEEF, err=0, fll_wr_no=1 throughout.
//  3. Model never acks, ACK_TIMEOUT=8 -> req drops after 8 cycles, access completes with err=1.
//  4. Lock held 0, LOCK_TIMEOUT=50 -> boot_err_o=1 at cycle 50 of WAIT_LOCK, ready_o=1.
//  5. rst_ni pulsed low while req=1 awaiting ack -> next cycle req=0, fll_rst_no=0, boot restarts.
//  6. sw_req_i held high across two accesses -> exactly one gnt per transfer, checker verifies
//     4-phase protocol and addr/data stability on every transfer.

Source files
------------

// File: rtl/fll_cfg_ctrl.sv
// fll_cfg_ctrl: sequencer for the FLL macro configuration port.
// Brings the FLL out of reset, writes two boot words, waits for lock, then
// serves single SoC read/write accesses over the 4-phase req/ack cfg port.
//
// Handshakes:
//   SoC side : sw_gnt_o is asserted combinationally in the cycle where the
//              controller is READY and sw_req_i is high; the request is taken
//              on that clock edge. Exactly one sw_rvalid_o pulse follows per
//              grant, carrying sw_rdata_o (reads) and sw_err_o.
//   FLL side : 4-phase. req rises with addr/wdata/wr_n stable, stays high
//              until synchronised ack is high (or timeout), then drops; the
//              next req only starts after synchronised ack has been seen low.
module fll_cfg_ctrl #(
  parameter bit          BOOT_EN      = 1'b1,
  parameter logic [31:0] BOOT_CFG1    = 32'h0000_0000,
  parameter logic [31:0] BOOT_CFG2    = 32'h0000_0000,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned ACK_TIMEOUT  = 256,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sw_req_i,
  input  logic        sw_we_i,
  input  logic [1:0]  sw_addr_i,
  input  logic [31:0] sw_wdata_i,
  output logic        sw_gnt_o,
  output logic        sw_rvalid_o,
  output logic [31:0] sw_rdata_o,
  output logic        sw_err_o,
  output logic        fll_rst_no,
  output logic        fll_req_o,
  input  logic        fll_ack_i,
  output logic [1:0]  fll_addr_o,
  output logic [31:0] fll_wdata_o,
  output logic        fll_wr_no,
  input  logic [31:0] fll_rdata_i,
  input  logic        fll_lock_i,
  output logic        ready_o,
  output logic        locked_o,
  output logic        boot_err_o
);

  typedef enum logic [2:0] {
    ST_RST_HOLD, ST_BOOT1, ST_BOOT2, ST_WAIT_LOCK, ST_READY, ST_ACCESS
  } state_e;

  // Transfer sub-phase used inside BOOT1/BOOT2/ACCESS.
  typedef enum logic [1:0] {XF_WAIT_ACK, XF_WAIT_LOW, XF_DONE} xfer_e;

  localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

  state_e      state_q, state_d;
  xfer_e       xph_q, xph_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ack_s1_q, ack_s2_q, lock_s1_q, lock_s2_q;
  logic        rst_n_q, rst_n_d;
  logic        req_q, req_d;
  logic        wr_n_q, wr_n_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        xerr_q, xerr_d;
  logic        boot_err_q, boot_err_d;

  logic        xfer_busy, xfer_done, sw_done;
  logic        start_xfer, start_wr_n;
  logic [1:0]  start_addr;
  logic [31:0] start_wdata;

  // Two-flop synchronisers for the asynchronous ack and lock inputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ack_s1_q  <= 1'b0;
      ack_s2_q  <= 1'b0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
    end else begin
      ack_s1_q  <= fll_ack_i;
      ack_s2_q  <= ack_s1_q;
      lock_s1_q <= fll_lock_i;
      lock_s2_q <= lock_s1_q;
    end
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_RST_HOLD;
      xph_q      <= XF_WAIT_ACK;
      cnt_q      <= '0;
      rst_n_q    <= 1'b0;
      req_q      <= 1'b0;
      wr_n_q     <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      xerr_q     <= 1'b0;
      boot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      xph_q      <= xph_d;
      cnt_q      <= cnt_d;
      rst_n_q    <= rst_n_d;
      req_q      <= req_d;
      wr_n_q     <= wr_n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      xerr_q     <= xerr_d;
      boot_err_q <= boot_err_d;
    end
  end

  // Next-state logic: shared transfer engine plus top-level sequencing.
  always_comb begin
    state_d     = state_q;
    xph_d       = xph_q;
    cnt_d       = cnt_q;
    rst_n_d     = rst_n_q;
    req_d       = req_q;
    wr_n_d      = wr_n_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    xerr_d      = xerr_q;
    boot_err_d  = boot_err_q;
    xfer_done   = 1'b0;
    start_xfer  = 1'b0;
    start_wr_n  = 1'b1;
    start_addr  = '0;
    start_wdata = '0;

    xfer_busy = ((state_q == ST_BOOT1) || (state_q == ST_BOOT2) ||
                 (state_q == ST_ACCESS)) && (xph_q != XF_DONE);

    // Phase 1 waits for ack high (or timeout), phase 2 for ack low (or timeout).
    if (xfer_busy) begin
      unique case (xph_q)
        XF_WAIT_ACK: begin
          if (ack_s2_q) begin
            rdata_d = fll_rdata_i;
            req_d   = 1'b0;
            xph_d   = XF_WAIT_LOW;
            cnt_d   = '0;
          end else if (cnt_q == ACK_LAST) begin
            req_d   = 1'b0;
            xerr_d  = 1'b1;
            xph_d   = XF_WAIT_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 16'd1;
          end
        end
        XF_WAIT_LOW: begin
          if (!ack_s2_q || (cnt_q == ACK_LAST)) begin
            xfer_done = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d     = cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end

    unique case (state_q)
      ST_RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          rst_n_d = 1'b1;
          cnt_d   = '0;
          if (BOOT_EN) begin
            state_d     = ST_BOOT1;
            start_xfer  = 1'b1;
            start_wr_n  = 1'b0;
            start_addr  = 2'd1;
            start_wdata = BOOT_CFG1;
          end else begin
            state_d = ST_READY;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_BOOT1: begin
        if (xfer_done) begin
          boot_err_d  = boot_err_q | xerr_q;
          state_d     = ST_BOOT2;
          start_xfer  = 1'b1;
          start_wr_n  = 1'b0;
          start_addr  = 2'd2;
          start_wdata = BOOT_CFG2;
        end
      end
      ST_BOOT2: begin
        if (xfer_done) begin
          boot_err_d = boot_err_q | xerr_q;
          state_d    = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s2_q) begin
          state_d = ST_READY;
        end else if (cnt_q == LOCK_LAST) begin
          boot_err_d = 1'b1;
          state_d    = ST_READY;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_READY: begin
        if (sw_req_i) begin
          state_d     = ST_ACCESS;
          start_xfer  = 1'b1;
          start_wr_n  = ~sw_we_i;
          start_addr  = sw_addr_i;
          start_wdata = sw_wdata_i;
        end
      end
      ST_ACCESS: begin
        // The DONE phase is the rvalid cycle; READY (and a new grant) follows.
        if (xph_q == XF_DONE) begin
          state_d = ST_READY;
        end else if (xfer_done) begin
          xph_d = XF_DONE;
        end
      end
      default: state_d = ST_RST_HOLD;
    endcase

    if (start_xfer) begin
      req_d   = 1'b1;
      wr_n_d  = start_wr_n;
      addr_d  = start_addr;
      wdata_d = start_wdata;
      xph_d   = XF_WAIT_ACK;
      cnt_d   = '0;
      xerr_d  = 1'b0;
    end
  end

  assign sw_done     = (state_q == ST_ACCESS) && (xph_q == XF_DONE);
  assign ready_o     = (state_q == ST_READY);
  assign sw_gnt_o    = rst_ni && ready_o && sw_req_i;
  assign sw_rvalid_o = sw_done;
  assign sw_rdata_o  = (sw_done && wr_n_q) ? rdata_q : '0;
  assign sw_err_o    = sw_done && xerr_q;
  assign fll_rst_no  = rst_n_q;
  assign fll_req_o   = req_q;
  assign fll_addr_o  = addr_q;
  assign fll_wdata_o = wdata_q;
  assign fll_wr_no   = wr_n_q;
  assign locked_o    = lock_s2_q;
  assign boot_err_o  = boot_err_q;

endmodule
